// File: rtl/piano_pkg.sv
// Shared definitions for the FPGA piano datapath.
//   MODE_LOWEST / MODE_LAST : selection policy codes for piano_key_select.MODE
//   NUM_KEYS_DEFAULT        : default keyboard width
//   note_idx_t              : note index type, also used by the tone generators
package piano_pkg;
  localparam int MODE_LOWEST      = 0;
  localparam int MODE_LAST        = 1;
  localparam int NUM_KEYS_DEFAULT = 8;
  localparam int NOTE_IDX_W       = $clog2(NUM_KEYS_DEFAULT);

  typedef logic [NOTE_IDX_W-1:0] note_idx_t;
endpackage

// File: rtl/key_debounce.sv
// Single-key front end: 2-flop synchroniser followed by a counting debouncer.
//   clk, reset : system clock, synchronous active-high reset
//   sw         : raw asynchronous key input (1 = pressed)
//   db         : debounced key state
//   rise/fall  : one-cycle flags, high in the first cycle db shows its new value
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Toggle happens on the sample that would bring the count to DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, rise_q, fall_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q   <= ~db_q;
          rise_q <= ~db_q;
          fall_q <= db_q;
          cnt_q  <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        // Any agreeing sample restarts the stability window.
        cnt_q <= '0;
      end
    end
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/piano_key_select.sv
// Keyboard front end: debounces NUM_KEYS keys and selects one active note.
//   clk, reset : system clock, synchronous active-high reset
//   sw         : raw key inputs (1 = pressed)
//   note_en    : registered one-hot enable of the selected note, 0 when none
//   note_idx   : index of the selected note, 0 when note_valid = 0
//   note_valid : a note is selected
//   note_on    : one-cycle pulse when a new note becomes selected
//   note_off   : one-cycle pulse when the previous selection ends
//   keys_db    : debounced key state
module piano_key_select
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MODE            = MODE_LOWEST,
  parameter int IDX_W           = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] sw,
  output logic [NUM_KEYS-1:0] note_en,
  output logic [IDX_W-1:0]    note_idx,
  output logic                note_valid,
  output logic                note_on,
  output logic                note_off,
  output logic [NUM_KEYS-1:0] keys_db
);
  logic [NUM_KEYS-1:0] db, rise, fall;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .sw   (sw[k]),
      .db   (db[k]),
      .rise (rise[k]),
      .fall (fall[k])
    );
  end

  // Index of the lowest set bit, 0 for an all-zero vector.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_KEYS-1:0] v);
    lowest_set = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--)
      if (v[i]) lowest_set = IDX_W'(i);
  endfunction

  logic                note_valid_q, note_valid_d;
  logic [IDX_W-1:0]    note_idx_q, note_idx_d;
  logic [NUM_KEYS-1:0] note_en_q, note_en_d;
  logic                note_on_q, note_on_d;
  logic                note_off_q, note_off_d;

  always_comb begin
    note_valid_d = 1'b0;
    note_idx_d   = '0;
    if (MODE == MODE_LOWEST) begin
      note_valid_d = |db;
      note_idx_d   = lowest_set(db);
    end else begin
      if (|rise) begin
        // A press always wins, even against a same-cycle release.
        note_valid_d = 1'b1;
        note_idx_d   = lowest_set(rise);
      end else if (note_valid_q && fall[note_idx_q]) begin
        note_valid_d = |db;
        note_idx_d   = lowest_set(db);
      end else begin
        note_valid_d = note_valid_q;
        note_idx_d   = note_idx_q;
      end
    end
    note_en_d  = note_valid_d ? ({{(NUM_KEYS-1){1'b0}}, 1'b1} << note_idx_d) : '0;
    note_on_d  = note_valid_d && (!note_valid_q || (note_idx_d != note_idx_q));
    note_off_d = note_valid_q && (!note_valid_d || (note_idx_d != note_idx_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_valid_q <= 1'b0;
      note_idx_q   <= '0;
      note_en_q    <= '0;
      note_on_q    <= 1'b0;
      note_off_q   <= 1'b0;
    end else begin
      note_valid_q <= note_valid_d;
      note_idx_q   <= note_idx_d;
      note_en_q    <= note_en_d;
      note_on_q    <= note_on_d;
      note_off_q   <= note_off_d;
    end
  end

  assign note_en    = note_en_q;
  assign note_idx   = note_idx_q;
  assign note_valid = note_valid_q;
  assign note_on    = note_on_q;
  assign note_off   = note_off_q;
  assign keys_db    = db;
endmodule

// File: tb/tb_piano_key_select.sv
module tb_piano_key_select;
  localparam int NK = 8;
  localparam int DB = 4;

  logic clk, reset;
  logic [NK-1:0] sw;

  // Index 0: lowest-index mode instance, index 1: last-pressed mode instance.
  logic [1:0][NK-1:0] en, kdb;
  logic [1:0][2:0]    idx;
  logic [1:0]         vld, on, off;

  piano_key_select #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .MODE(0)) u_lo (
    .clk(clk), .reset(reset), .sw(sw), .note_en(en[0]), .note_idx(idx[0]),
    .note_valid(vld[0]), .note_on(on[0]), .note_off(off[0]), .keys_db(kdb[0]));

  piano_key_select #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .MODE(1)) u_la (
    .clk(clk), .reset(reset), .sw(sw), .note_en(en[1]), .note_idx(idx[1]),
    .note_valid(vld[1]), .note_on(on[1]), .note_off(off[1]), .keys_db(kdb[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int on_cnt[2];
  int off_cnt[2];

  // Reference model: synchroniser pipeline, debounced state, stable run
  // lengths and the currently selected note for each mode.
  logic [NK-1:0] m_s1, m_s2, m_db, m_dbold;
  int            m_run[NK];
  logic          m_valid[2], m_on[2], m_off[2];
  int            m_idx[2];

  function automatic int lowest(input logic [NK-1:0] v);
    for (int i = 0; i < NK; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step();
    logic [NK-1:0] rise;
    logic nv;
    int ni;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dbold = '0;
      for (int i = 0; i < NK; i++) m_run[i] = 0;
      for (int m = 0; m < 2; m++) begin
        m_valid[m] = 0; m_idx[m] = 0; m_on[m] = 0; m_off[m] = 0;
      end
    end else begin
      rise = m_db & ~m_dbold;
      for (int m = 0; m < 2; m++) begin
        nv = m_valid[m]; ni = m_idx[m];
        if (m == 0) begin
          nv = |m_db; ni = lowest(m_db);
        end else if (|rise) begin
          nv = 1; ni = lowest(rise);
        end else if (m_valid[m] && !m_db[m_idx[m]]) begin
          nv = |m_db; ni = lowest(m_db);
        end
        m_on[m]  = nv && (!m_valid[m] || ni != m_idx[m]);
        m_off[m] = m_valid[m] && (!nv || ni != m_idx[m]);
        m_valid[m] = nv; m_idx[m] = ni;
      end
      m_dbold = m_db;
      for (int i = 0; i < NK; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin m_db[i] = ~m_db[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      m_s2 = m_s1;
      m_s1 = sw;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [NK-1:0] een;
    for (int m = 0; m < 2; m++) begin
      een = m_valid[m] ? (8'h01 << m_idx[m]) : 8'h00;
      chk($sformatf("m%0d_en", m),    32'(en[m]),  32'(een));
      chk($sformatf("m%0d_idx", m),   32'(idx[m]), 32'(m_valid[m] ? m_idx[m] : 0));
      chk($sformatf("m%0d_valid", m), 32'(vld[m]), 32'(m_valid[m]));
      chk($sformatf("m%0d_on", m),    32'(on[m]),  32'(m_on[m]));
      chk($sformatf("m%0d_off", m),   32'(off[m]), 32'(m_off[m]));
      chk($sformatf("m%0d_kdb", m),   32'(kdb[m]), 32'(m_db));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    for (int m = 0; m < 2; m++) begin
      if (on[m] === 1'b1)  on_cnt[m]++;
      if (off[m] === 1'b1) off_cnt[m]++;
    end
  endtask

  task automatic clr_cnt();
    for (int m = 0; m < 2; m++) begin on_cnt[m] = 0; off_cnt[m] = 0; end
  endtask

  initial begin
    reset = 1'b1; sw = '0;
    clr_cnt();
    repeat (3) cyc();
    reset = 1'b0;
    repeat (2) cyc();
    chk("rst_valid", 32'(vld[0]), 0);
    chk("rst_en", 32'(en[1]), 0);

    // Single press: output appears at the 7th edge after the change.
    clr_cnt();
    sw = 8'h08;
    repeat (6) cyc();
    chk("press_early", 32'(vld[0]), 0);
    cyc();
    chk("press_idx", 32'(idx[0]), 3);
    chk("press_en", 32'(en[0]), 32'h08);
    chk("press_on", 32'(on[0]), 1);
    repeat (5) cyc();
    chk("press_on_cnt", 32'(on_cnt[0]), 1);

    // Glitch shorter than the debounce window.
    sw = 8'h28;
    repeat (3) cyc();
    sw = 8'h08;
    repeat (8) cyc();
    chk("glitch_kdb", 32'(kdb[0]), 32'h08);
    chk("glitch_idx", 32'(idx[0]), 3);

    // Lowest mode: 6 held, 2 pressed, 2 released.
    sw = 8'h00; repeat (10) cyc();
    sw = 8'h40; repeat (10) cyc();
    chk("lo_hold6", 32'(idx[0]), 6);
    sw = 8'h44; repeat (7) cyc();
    chk("lo_6to2_idx", 32'(idx[0]), 2);
    chk("lo_6to2_on", 32'(on[0]), 1);
    chk("lo_6to2_off", 32'(off[0]), 1);
    sw = 8'h40; repeat (10) cyc();
    chk("lo_back6", 32'(idx[0]), 6);
    chk("la_back6", 32'(idx[1]), 6);

    // Last-pressed mode.
    sw = 8'h00; repeat (10) cyc();
    sw = 8'h02; repeat (10) cyc();
    sw = 8'h42; repeat (10) cyc();
    chk("la_last6", 32'(idx[1]), 6);
    chk("lo_low1", 32'(idx[0]), 1);
    sw = 8'h02; repeat (10) cyc();
    chk("la_fall1", 32'(idx[1]), 1);
    sw = 8'h32; repeat (10) cyc();
    chk("la_tie4", 32'(idx[1]), 4);
    chk("la_tie_en", 32'(en[1]), 32'h10);

    // Release all: a single note_off each.
    clr_cnt();
    sw = 8'h00; repeat (10) cyc();
    chk("rel_off_lo", 32'(off_cnt[0]), 1);
    chk("rel_off_la", 32'(off_cnt[1]), 1);
    chk("rel_valid", 32'(vld[1]), 0);
    chk("rel_en", 32'(en[0]), 0);

    // Reset mid-debounce discards the partial count.
    clr_cnt();
    sw = 8'h01; repeat (4) cyc();
    reset = 1'b1; repeat (2) cyc();
    reset = 1'b0;
    chk("rstdb_on", 32'(on_cnt[0]), 0);
    repeat (6) cyc();
    chk("rstdb_early", 32'(vld[0]), 0);
    cyc();
    chk("rstdb_valid", 32'(vld[0]), 1);
    chk("rstdb_on_cnt", 32'(on_cnt[0]), 1);

    // Reset while a note is held gives no note_off.
    clr_cnt();
    reset = 1'b1; repeat (2) cyc();
    reset = 1'b0; cyc();
    chk("rsthold_off_lo", 32'(off_cnt[0]), 0);
    chk("rsthold_off_la", 32'(off_cnt[1]), 0);

    // Randomised key activity with occasional resets.
    for (int n = 0; n < 120; n++) begin
      sw = NK'($urandom);
      reset = ($urandom_range(0, 29) == 0);
      repeat ($urandom_range(1, 9)) cyc();
      reset = 1'b0;
    end
    sw = '0; repeat (12) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
